// File: rtl/aftab_wait_state_mem.sv
// ----------------------------------------------------------------------------
// aftab_wait_state_mem
//   Registered memory slave for the AFTAB core memory port. It inserts a
//   configurable number of wait states before a one-cycle memReady strobe. It
//   decodes an address window, flags rejected accesses with memError, and
//   stores data in an internal byte array using little-endian lane order.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   memRead     : read request, held by the core until memReady
//   memWrite    : write request, held by the core until memReady
//   memAddr     : byte address, stable while a request is held
//   memDataIn   : write data, DATA_WIDTH bits
//   memDataOut  : registered read data (zero after a rejected access)
//   memReady    : one-cycle completion strobe
//   memError    : qualifies memReady, high for a rejected access
//   busy        : high while a transaction is in flight
//
// Timing, with E0 as the IDLE edge that samples the request:
//   memReady is high after edge E(WAIT_STATES) for one cycle. busy is high
//   from E0 until E(WAIT_STATES+1). The earliest next sampling edge is
//   E(WAIT_STATES+2).
// ----------------------------------------------------------------------------
module aftab_wait_state_mem #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    output logic [DATA_WIDTH-1:0] memDataOut,
    output logic                  memReady,
    output logic                  memError,
    output logic                  busy
);

    localparam int unsigned LANES      = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned TAG_W      = ADDR_WIDTH - IDX_W;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned CNT_INIT_I = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

    localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(CNT_INIT_I);
    localparam logic [TAG_W-1:0]      BASE_TAG  = BASE_ADDR[ADDR_WIDTH-1:IDX_W];
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Control and latched transaction registers
    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_wr;
    logic                    r_err;
    logic [IDX_W-1:0]        r_off;
    logic [DATA_WIDTH-1:0]   r_wdata;

    // Registered outputs
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_ready;
    logic                    r_error;
    logic                    r_busy;

    // Byte storage. It is not reset, so its contents are whatever the flow preloads.
    logic [7:0]              r_mem [DEPTH];

    logic                    w_req;
    logic                    w_idle;
    logic                    w_in_window;
    logic                    w_misalign;
    logic                    w_err_in;
    logic                    w_enter_resp;
    logic                    w_sel_wr;
    logic                    w_sel_err;
    logic [IDX_W-1:0]        w_off;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_commit_wr;

    assign w_req  = memRead | memWrite;
    assign w_idle = (r_state == S_IDLE);

    // Rejection checks on the live request. These are used only at the IDLE sampling edge.
    assign w_in_window = (memAddr[ADDR_WIDTH-1:IDX_W] == BASE_TAG);
    assign w_misalign  = ((memAddr & LANE_MASK) != '0);
    assign w_err_in    = !w_in_window | w_misalign | (memRead & memWrite);

    // With zero wait states, RESP is entered on the sampling edge itself.
    // In that case the live inputs stand in for the latched copies.
    assign w_sel_wr   = w_idle ? memWrite                 : r_wr;
    assign w_sel_err  = w_idle ? w_err_in                 : r_err;
    assign w_off      = w_idle ? memAddr[IDX_W-1:0]       : r_off;
    assign w_sel_data = w_idle ? memDataIn                : r_wdata;

    assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == '0))
                        || (w_idle && w_req && (WAIT_STATES == 0));

    assign w_commit_wr = w_enter_resp & w_sel_wr & !w_sel_err;

    // Little-endian lane gather. Byte i is read from offset + i.
    for (genvar g = 0; g < LANES; g++) begin : g_rd_lane
        assign w_rdata[8*g +: 8] = r_mem[w_off + IDX_W'(g)];
    end

    // Transaction state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin : p_fsm
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_off   <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= w_enter_resp;
            r_error <= w_enter_resp & w_sel_err;

            // Read data is loaded on RESP entry. A legal write leaves it untouched.
            if (w_enter_resp) begin
                if (w_sel_err) begin
                    r_dout <= '0;
                end else if (!w_sel_wr) begin
                    r_dout <= w_rdata;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_wr    <= memWrite;
                        r_err   <= w_err_in;
                        r_off   <= memAddr[IDX_W-1:0];
                        r_wdata <= memDataIn;
                        r_busy  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane commit of a legal write, little-endian
    always_ff @(posedge clk) begin : p_mem
        if (w_commit_wr) begin
            for (int i = 0; i < LANES; i++) begin
                r_mem[w_off + IDX_W'(i)] <= w_sel_data[8*i +: 8];
            end
        end
    end

    assign memDataOut = r_dout;
    assign memReady   = r_ready;
    assign memError   = r_error;
    assign busy       = r_busy;

endmodule
